uart_imem_loader: RTL and testbench
===================================

# uart_imem_loader

Bootloader stage directly downstream of the UART receive controller. Deserialises the per-bit strobe stream into bytes, packs bytes little-endian into 32-bit words, and writes them to sequential instruction-memory word addresses. It holds the pipelined core in reset until a complete, length-prefixed program image has been loaded.

## Interface
- `DEPTH`, 1024: instruction-memory capacity in 32-bit words.
- `ADDR_W`, `$clog2(DEPTH)`: word-address width.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `bit_en` in 1: receiver reception-window enable; one bit is shifted in each cycle it is high.
- `bit_in` in 1: registered serial sample from the receiver, LSB first.
- `byte_done` in 1: one-cycle pulse; a complete byte is in the shifter.
- `imem_we` out 1: one-cycle instruction-memory write strobe.
- `imem_addr` out ADDR_W: word address for the write.
- `imem_wdata` out 32: write data.
- `load_busy` out 1: high from reset release until DONE or ERR; holds the core in reset.
- `load_done` out 1: image loaded successfully (sticky).
- `load_error` out 1: image rejected (sticky).
- `words_loaded` out ADDR_W+1: count of words written.

## Operation
- Shifter: on each `bit_en` cycle, `sh <= {bit_in, sh[7:1]}`. The receiver window is 9 cycles and the first sample is stale, so only the last 8 samples remain. `byte_done` latches `sh` as the byte. `sh` is not cleared between bytes.
- Packing: `byte_idx` (2 bits) selects the lane; byte k goes to bits [8k+7:8k]. The fourth byte completes the word.
- FSM states: LEN, DATA, CSUM (macro only), DONE, ERR.
  - LEN: collects 4 bytes into `len`. If `len == 0`, go to DONE (or CSUM with the macro). If `len > DEPTH`, go to ERR. Otherwise go to DATA.
  - DATA: each completed word issues a write at `imem_addr = words_loaded`, then `words_loaded` increments. When `words_loaded` reaches `len`, go to DONE (or CSUM).
  - DONE and ERR: terminal until `rst`. Any `byte_done` in these states is ignored, and no writes occur.
- Width rules:
  - `len` is 32 bits; the comparison against DEPTH uses the full 32 bits.
  - `words_loaded` never exceeds `len` and never exceeds DEPTH.
  - `imem_addr` never wraps.
- `bit_en` and `byte_done` are never high in the same cycle. If they are, `byte_done` takes priority and the shift is dropped.

## Timing
- Reset values: `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `load_busy`=1, `load_done`=0, `load_error`=0, `words_loaded`=0. State is LEN, `byte_idx`=0, shifter is 0.
- Write latency: `byte_done` in cycle t (fourth byte of a word) produces `imem_we`=1 in t+1, with the address and data valid in t+1. `imem_we` lasts exactly 1 cycle. The memory accepts one write per cycle with no backpressure.
- The final write in cycle t+1 is followed by `load_done`=1 and `load_busy`=0 in t+2 (without the macro).
- An ERR transition raises `load_error` and clears `load_busy` one cycle after the offending `byte_done`.
- Reset mid-load returns everything to reset values immediately. Partially written memory is not scrubbed.

## Configuration
- `UART_LOADER_CHECKSUM_EN`:
  - Defined: after the last data word (or after LEN when `len == 0`), the CSUM state takes one more byte. The block compares it against the XOR of all preceding bytes, including the length bytes.
  - On a match, DONE is set one cycle after that `byte_done`. On a mismatch, ERR is set.
  - Undefined: there is no CSUM state, no XOR register, and the DATA→DONE transition is direct.

## Structure
- `uart_loader_pkg` contains:
  - the state enum `loader_state_e`;
  - `BYTES_PER_WORD = 4`;
  - `LEN_BYTES = 4`.
- Sub-module `uart_byte_shifter` holds the 8-bit shifter and the byte latch on `byte_done`, with outputs `byte_q` and `byte_vld`. The top module holds the FSM, packing, counters, and checksum.

## Test plan
- Reset then idle: all outputs at reset values, `load_busy`=1, no `imem_we` over 100 cycles.
- `len`=2, words 0x00000013 and 0xDEADBEEF sent as bytes 02 00 00 00 13 00 00 00 EF BE AD DE:
  - writes (0,0x00000013) and (1,0xDEADBEEF);
  - `load_done`=1 two cycles after the last `byte_done`;
  - `words_loaded`=2.
- `len`=0: `load_done` without any `imem_we`. With the macro, the checksum byte 00 is required.
- `len`=DEPTH+1: `load_error`=1, and no writes for 16 subsequent bytes.
- `rst` pulsed after 6 bytes, then a full `len`=1 image: the first write goes to address 0 with correct data.
- With `UART_LOADER_CHECKSUM_EN`, `len`=1 word 0x11223344:
  - checksum 0x45 gives `load_done`;
  - checksum 0x46 gives `load_error`;
  - the write to address 0 occurs in both cases.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
// Optional feature macro: UART_LOADER_CHECKSUM_EN (adds the CSUM state).
package uart_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 4;

    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_DATA = 3'd1,
`ifdef UART_LOADER_CHECKSUM_EN
        ST_CSUM = 3'd2,
`endif
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } loader_state_e;

endpackage

// File: rtl/uart_byte_shifter.sv
// Serial-to-parallel shifter for the UART receive strobe stream.
// The receiver window is 9 samples wide with a stale first sample, so after a
// full window only the last 8 samples (LSB first) remain in the shifter.
// The byte is presented on byte_q together with byte_vld in the byte_done
// cycle; the consumer captures it on the same clock edge.
module uart_byte_shifter (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_en_i,
    input  logic       bit_in_i,
    input  logic       byte_done_i,
    output logic [7:0] byte_q,
    output logic       byte_vld
);

    logic [7:0] sh_q;
    logic [7:0] sh_d;

    // Next shifter value: byte_done wins over a coincident bit strobe, and
    // the shifter is never cleared between bytes.
    always_comb begin
        sh_d = sh_q;
        if (byte_done_i) begin
            sh_d = sh_q;
        end else if (bit_en_i) begin
            sh_d = {bit_in_i, sh_q[7:1]};
        end
    end

    // Shifter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q <= 8'h00;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign byte_q   = sh_q;
    assign byte_vld = byte_done_i;

endmodule

// File: rtl/uart_imem_loader.sv
// Bootloader: receives a length-prefixed program image over the UART byte
// stream, packs bytes little-endian into 32-bit words and writes them to
// sequential instruction-memory addresses while holding the core in reset.
// Optional feature macro: UART_LOADER_CHECKSUM_EN -- a trailing XOR checksum
// byte over all preceding bytes (length included) must match for DONE.
module uart_imem_loader
    import uart_loader_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              bit_in,
    input  logic              byte_done,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    logic [7:0] rx_byte;
    logic       rx_vld;

    uart_byte_shifter u_shifter (
        .clk         (clk),
        .rst         (rst),
        .bit_en_i    (bit_en),
        .bit_in_i    (bit_in),
        .byte_done_i (byte_done),
        .byte_q      (rx_byte),
        .byte_vld    (rx_vld)
    );

    loader_state_e     state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       word_asm;
    logic              last_len_lane;
    logic              last_data_lane;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    // State entered once the payload (possibly empty) has been consumed.
    function automatic loader_state_e after_payload();
`ifdef UART_LOADER_CHECKSUM_EN
        return ST_CSUM;
`else
        return ST_DONE;
`endif
    endfunction

    // Next-state, packing and write-issue logic.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        len_d      = len_q;
        words_d    = words_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef UART_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        word_asm                     = word_q;
        word_asm[8*byte_idx_q +: 8]  = rx_byte;
        last_len_lane                = (byte_idx_q == 2'(LEN_BYTES - 1));
        last_data_lane               = (byte_idx_q == 2'(BYTES_PER_WORD - 1));

        case (state_q)
            ST_LEN: begin
                if (rx_vld) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    word_d     = word_asm;
`ifdef UART_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ rx_byte;
`endif
                    if (last_len_lane) begin
                        // Full 32-bit compare so upper length bits are never lost.
                        if (word_asm == 32'd0) begin
                            state_d = after_payload();
                        end else if (word_asm > 32'(DEPTH)) begin
                            state_d = ST_ERR;
                        end else begin
                            len_d   = word_asm[ADDR_W:0];
                            state_d = ST_DATA;
                        end
                    end
                end
            end
            ST_DATA: begin
                // Leave one cycle after the final write so DONE trails it.
                if (words_q == len_q) begin
                    state_d = after_payload();
                end else if (rx_vld) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    word_d     = word_asm;
`ifdef UART_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ rx_byte;
`endif
                    if (last_data_lane) begin
                        we_d    = 1'b1;
                        addr_d  = words_q[ADDR_W-1:0];
                        wdata_d = word_asm;
                        words_d = words_q + {{ADDR_W{1'b0}}, 1'b1};
                    end
                end
            end
`ifdef UART_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (rx_vld) begin
                    state_d = (rx_byte == csum_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    // Loader registers; reset returns every output to its idle value at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LEN;
            byte_idx_q <= 2'd0;
            word_q     <= 32'd0;
            len_q      <= '0;
            words_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
`ifdef UART_LOADER_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            len_q      <= len_d;
            words_q    <= words_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifdef UART_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = words_q;
    assign load_done    = (state_q == ST_DONE);
    assign load_error   = (state_q == ST_ERR);
    assign load_busy    = !(load_done || load_error);

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader with a write scoreboard.
// Optional feature macro: UART_LOADER_CHECKSUM_EN (must match the RTL build).
module tb_uart_imem_loader;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              bit_en;
    logic              bit_in;
    logic              byte_done;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              load_busy;
    logic              load_done;
    logic              load_error;
    logic [ADDR_W:0]   words_loaded;

    uart_imem_loader #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .bit_en       (bit_en),
        .bit_in       (bit_in),
        .byte_done    (byte_done),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .load_busy    (load_busy),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    wr_t        exp_q[$];
    int         cyc    = 0;
    int         bd_cyc = -10;
    int         tests  = 0;
    int         fails  = 0;
    int         writes = 0;
    logic [7:0] xsum   = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write must match the next expected (addr,data) and
    // appear exactly one cycle after the byte_done that completed the word.
    always @(negedge clk) begin
        wr_t e;
        if (imem_we === 1'b1) begin
            writes++;
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_write: observed addr 0x%0h data 0x%08h expected no write",
                       imem_addr, imem_wdata);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(e.a));
                check("wr_data", imem_wdata, e.d);
                check("wr_latency", 32'(cyc), 32'(bd_cyc + 1));
            end
        end
    end

    // One receiver window (stale sample + 8 bits LSB first) then byte_done.
    // Returns #1 into the cycle after the byte_done cycle.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bit_en = 1'b1;
        bit_in = 1'($urandom_range(0, 1));
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            bit_in = b[i];
        end
        @(posedge clk); #1;
        bit_en    = 1'b0;
        bit_in    = 1'b0;
        byte_done = 1'b1;
        bd_cyc    = cyc;
        xsum      = xsum ^ b;
        @(posedge clk); #1;
        byte_done = 1'b0;
    endtask

    task automatic send_len(input logic [31:0] l);
        for (int k = 0; k < 4; k++) send_byte(l[8*k +: 8]);
    endtask

    task automatic send_word(input logic [31:0] w, input int addr);
        wr_t e;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                e.a = ADDR_W'(addr);
                e.d = w;
                exp_q.push_back(e);
            end
            send_byte(w[8*k +: 8]);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        xsum = 8'h00;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Called right after the last data byte of an image.
    task automatic close_image(input string tag);
        logic [7:0] c;
`ifdef UART_LOADER_CHECKSUM_EN
        check({tag, "_busy_csum"}, 32'(load_busy), 32'd1);
        repeat (2) @(posedge clk);
        c = xsum;
        send_byte(c);
`else
        check({tag, "_done_early"}, 32'(load_done), 32'd0);
        @(posedge clk); #1;
`endif
        check({tag, "_done"}, 32'(load_done), 32'd1);
        check({tag, "_busy"}, 32'(load_busy), 32'd0);
        check({tag, "_err"},  32'(load_error), 32'd0);
    endtask

    initial begin
        int w0;
        logic [7:0] c;
        bit_en    = 1'b0;
        bit_in    = 1'b0;
        byte_done = 1'b0;
        rst       = 1'b1;
        #1;
        check("rst_async_busy", 32'(load_busy), 32'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values and idle behaviour.
        check("rst_we",    32'(imem_we), 32'd0);
        check("rst_addr",  32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_busy",  32'(load_busy), 32'd1);
        check("rst_done",  32'(load_done), 32'd0);
        check("rst_err",   32'(load_error), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        repeat (100) @(posedge clk);
        #1;
        check("idle_writes", 32'(writes), 32'd0);
        check("idle_busy",   32'(load_busy), 32'd1);

        // Two-word image.
        send_len(32'd2);
        send_word(32'h0000_0013, 0);
        check("len2_words_mid", 32'(words_loaded), 32'd1);
        send_word(32'hDEAD_BEEF, 1);
        check("len2_words", 32'(words_loaded), 32'd2);
        close_image("len2");
        w0 = writes;
        for (int k = 0; k < 4; k++) send_byte(8'hAA);
        check("done_ignore_writes", 32'(writes), 32'(w0));
        check("done_sticky", 32'(load_done), 32'd1);
        check("done_words", 32'(words_loaded), 32'd2);

        // Empty image.
        apply_reset();
        w0 = writes;
        send_len(32'd0);
`ifdef UART_LOADER_CHECKSUM_EN
        check("len0_busy_csum", 32'(load_done), 32'd0);
        c = xsum;
        send_byte(c);
`endif
        check("len0_done", 32'(load_done), 32'd1);
        check("len0_busy", 32'(load_busy), 32'd0);
        check("len0_writes", 32'(writes), 32'(w0));

        // Oversized image.
        apply_reset();
        send_len(32'(DEPTH + 1));
        check("big_err",  32'(load_error), 32'd1);
        check("big_busy", 32'(load_busy), 32'd0);
        check("big_done", 32'(load_done), 32'd0);
        w0 = writes;
        for (int k = 0; k < 16; k++) send_byte(8'($urandom_range(0, 255)));
        check("big_writes", 32'(writes), 32'(w0));
        check("big_err_sticky", 32'(load_error), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_err",  32'(load_error), 32'd0);
        check("async_rst_busy", 32'(load_busy), 32'd1);
        apply_reset();

        // Length whose low bits are zero must still be rejected.
        send_len(32'h0001_0000);
        check("hi_len_err",  32'(load_error), 32'd1);
        check("hi_len_done", 32'(load_done), 32'd0);
        apply_reset();

        // Reset after 6 bytes, then a full one-word image.
        send_len(32'd1);
        send_byte(8'h44);
        send_byte(8'h33);
        apply_reset();
        check("midrst_words", 32'(words_loaded), 32'd0);
        send_len(32'd1);
        send_word(32'hCAFE_F00D, 0);
        check("midrst_words_after", 32'(words_loaded), 32'd1);
        close_image("midrst");

`ifdef UART_LOADER_CHECKSUM_EN
        // Checksum accepted and rejected.
        apply_reset();
        send_len(32'd1);
        send_word(32'h1122_3344, 0);
        repeat (2) @(posedge clk);
        send_byte(8'h45);
        check("csum_ok_done", 32'(load_done), 32'd1);
        check("csum_ok_err",  32'(load_error), 32'd0);
        apply_reset();
        send_len(32'd1);
        send_word(32'h1122_3344, 0);
        repeat (2) @(posedge clk);
        send_byte(8'h46);
        check("csum_bad_err",  32'(load_error), 32'd1);
        check("csum_bad_done", 32'(load_done), 32'd0);
        check("csum_bad_words", 32'(words_loaded), 32'd1);
`endif

        repeat (4) @(posedge clk);
        #1;
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
